// File: rtl/encoder8x3_serial.sv
// encoder8x3_serial: sequential 8-to-3 encoder.
// Accepts a multi-hot request vector over a valid/ready handshake and hands
// out the index of every set bit, lowest first, one per output handshake.
// All outputs are derived from registered state only, so nothing on the
// in_* side can reach the out_* side within a single cycle.
module encoder8x3_serial #(
  parameter int N = 8,
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_vec,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_idx,
  output logic         out_last,
  output logic [W:0]   remaining,
  output logic         err_empty
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t       state;
  state_t       next_state;
  logic [N-1:0] shadow;
  logic [N-1:0] next_shadow;
  logic [W:0]   next_remaining;
  logic         next_err;
  logic [W:0]   in_count;
  logic [W-1:0] low_idx;

  // Count the set bits of the incoming vector so BUSY knows how many handoffs remain
  always_comb begin
    in_count = '0;
    for (int i = 0; i < N; i++) begin
      in_count = in_count + (W+1)'(in_vec[i]);
    end
  end

  // Find the lowest set bit still pending; scanning downwards lets the lowest hit win
  always_comb begin
    low_idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (shadow[i]) begin
        low_idx = W'(i);
      end
    end
  end

  // Next-state logic: accept in IDLE, retire one bit per output handshake in BUSY
  always_comb begin
    next_state     = state;
    next_shadow    = shadow;
    next_remaining = remaining;
    next_err       = 1'b0;
    case (state)
      IDLE: begin
        if (in_valid) begin
          if (in_vec == '0) begin
            next_err = 1'b1;
          end else begin
            next_shadow    = in_vec;
            next_remaining = in_count;
            next_state     = BUSY;
          end
        end
      end
      BUSY: begin
        if (out_ready) begin
          next_shadow    = shadow & ~(N'(1) << low_idx);
          next_remaining = remaining - (W+1)'(1);
          if (remaining == (W+1)'(1)) begin
            next_state = IDLE;
          end
        end
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Handshake outputs come straight from the state and the shadow register
  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == BUSY);
    out_idx   = low_idx;
    out_last  = (state == BUSY) && (remaining == (W+1)'(1));
  end

  // State register; reset discards any vector in progress
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      shadow    <= '0;
      remaining <= '0;
      err_empty <= 1'b0;
    end else begin
      state     <= next_state;
      shadow    <= next_shadow;
      remaining <= next_remaining;
      err_empty <= next_err;
    end
  end

endmodule

// File: tb/tb_encoder8x3_serial.sv
// tb_encoder8x3_serial: vector table, hand-written corner sequences and
// random traffic, all compared against a queue-based reference model.
module tb_encoder8x3_serial;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_vec;
  logic       out_valid;
  logic       out_ready;
  logic [2:0] out_idx;
  logic       out_last;
  logic [3:0] remaining;
  logic       err_empty;

  int checks = 0;
  int errors = 0;

  // Reference model: the indices still to be handed out, in order
  int pend[$];
  bit mErr;
  // Indices observed crossing the output handshake
  int hs[$];

  typedef struct {
    bit         r;
    bit         iv;
    logic [7:0] vec;
    bit         ordy;
    bit         eValid;
    int         eIdx;
    bit         eLast;
    int         eRem;
    bit         eRdy;
    bit         eErr;
  } vec_t;

  vec_t tbl[10];

  encoder8x3_serial #(.N(8), .W(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_vec    (in_vec),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_idx   (out_idx),
    .out_last  (out_last),
    .remaining (remaining),
    .err_empty (err_empty)
  );

  // Free-running clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkVal(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Advance the model by one clock edge with the given inputs
  task automatic modelStep(input bit r, input bit iv, input logic [7:0] vec, input bit ordy);
    if (r) begin
      pend.delete();
      mErr = 1'b0;
    end else if (pend.size() == 0) begin
      mErr = iv && (vec == 8'h00);
      if (iv && vec != 8'h00) begin
        for (int i = 0; i < 8; i++) begin
          if (vec[i]) pend.push_back(i);
        end
      end
    end else begin
      mErr = 1'b0;
      if (ordy) void'(pend.pop_front());
    end
  endtask

  task automatic checkOutput(input string tag);
    checkVal({tag, "_out_valid"}, int'(out_valid), (pend.size() > 0) ? 1 : 0);
    checkVal({tag, "_in_ready"},  int'(in_ready),  (pend.size() == 0) ? 1 : 0);
    checkVal({tag, "_out_idx"},   int'(out_idx),   (pend.size() > 0) ? pend[0] : 0);
    checkVal({tag, "_out_last"},  int'(out_last),  (pend.size() == 1) ? 1 : 0);
    checkVal({tag, "_remaining"}, int'(remaining), pend.size());
    checkVal({tag, "_err_empty"}, int'(err_empty), int'(mErr));
  endtask

  // Drive inputs for one cycle (called just after a falling edge), record any
  // output handshake, step the model at the rising edge, then check
  task automatic applyStimulus(input string tag, input bit r, input bit iv,
                               input logic [7:0] vec, input bit ordy);
    rst       = r;
    in_valid  = iv;
    in_vec    = vec;
    out_ready = ordy;
    #1;
    if (!r && out_valid && out_ready) hs.push_back(int'(out_idx));
    @(posedge clk);
    modelStep(r, iv, vec, ordy);
    @(negedge clk);
    checkOutput(tag);
  endtask

  initial begin
    int pat[4];
    int cyc;
    int sel;
    bit r;
    logic [7:0] v;

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_vec    = 8'h00;
    out_ready = 1'b0;
    mErr      = 1'b0;

    // Reset, 8'b1010_0101 streamed, 8'h80 single index, 8'h00 empty error
    tbl[0] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 0, 1'b0, 0, 1'b1, 1'b0};
    tbl[1] = '{1'b0, 1'b1, 8'hA5, 1'b1, 1'b1, 0, 1'b0, 4, 1'b0, 1'b0};
    tbl[2] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 2, 1'b0, 3, 1'b0, 1'b0};
    tbl[3] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 5, 1'b0, 2, 1'b0, 1'b0};
    tbl[4] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 7, 1'b1, 1, 1'b0, 1'b0};
    tbl[5] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 0, 1'b0, 0, 1'b1, 1'b0};
    tbl[6] = '{1'b0, 1'b1, 8'h80, 1'b1, 1'b1, 7, 1'b1, 1, 1'b0, 1'b0};
    tbl[7] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 0, 1'b0, 0, 1'b1, 1'b0};
    tbl[8] = '{1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 0, 1'b0, 0, 1'b1, 1'b1};
    tbl[9] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 0, 1'b0, 0, 1'b1, 1'b0};

    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      applyStimulus($sformatf("tbl%0d", i), tbl[i].r, tbl[i].iv, tbl[i].vec, tbl[i].ordy);
      checkVal($sformatf("tbl%0d_valid", i), int'(out_valid), int'(tbl[i].eValid));
      checkVal($sformatf("tbl%0d_idx", i),   int'(out_idx),   tbl[i].eIdx);
      checkVal($sformatf("tbl%0d_last", i),  int'(out_last),  int'(tbl[i].eLast));
      checkVal($sformatf("tbl%0d_rem", i),   int'(remaining), tbl[i].eRem);
      checkVal($sformatf("tbl%0d_rdy", i),   int'(in_ready),  int'(tbl[i].eRdy));
      checkVal($sformatf("tbl%0d_err", i),   int'(err_empty), int'(tbl[i].eErr));
    end

    // 8'hFF under a 1,0,0,1 out_ready pattern: every index exactly once, in order
    pat = '{1, 0, 0, 1};
    hs.delete();
    applyStimulus("ff_accept", 1'b0, 1'b1, 8'hFF, 1'b0);
    cyc = 0;
    while (pend.size() > 0 && cyc < 40) begin
      applyStimulus($sformatf("ff_c%0d", cyc), 1'b0, 1'b0, 8'h00, pat[cyc % 4] != 0);
      cyc++;
    end
    checkVal("ff_drained_in_bound", (pend.size() == 0) ? 1 : 0, 1);
    checkVal("ff_handshake_count", hs.size(), 8);
    for (int k = 0; k < 8; k++) begin
      checkVal($sformatf("ff_hs%0d", k), (k < hs.size()) ? hs[k] : -1, k);
    end

    // 8'h3C with reset after the second handshake, then a fresh 8'h01
    applyStimulus("rs_accept", 1'b0, 1'b1, 8'h3C, 1'b1);
    applyStimulus("rs_hs2", 1'b0, 1'b0, 8'h00, 1'b1);
    applyStimulus("rs_hs3", 1'b0, 1'b0, 8'h00, 1'b1);
    applyStimulus("rs_reset", 1'b1, 1'b0, 8'h00, 1'b1);
    checkVal("rs_reset_out_valid", int'(out_valid), 0);
    checkVal("rs_reset_remaining", int'(remaining), 0);
    checkVal("rs_reset_in_ready", int'(in_ready), 1);
    applyStimulus("rs_new", 1'b0, 1'b1, 8'h01, 1'b1);
    checkVal("rs_new_out_idx", int'(out_idx), 0);
    checkVal("rs_new_out_last", int'(out_last), 1);
    applyStimulus("rs_done", 1'b0, 1'b0, 8'h00, 1'b1);

    // in_valid held high: 8'h06 then 8'h41, second vector waits for IDLE
    hs.delete();
    applyStimulus("hold_a", 1'b0, 1'b1, 8'h06, 1'b1);
    for (int k = 0; k < 4; k++) begin
      applyStimulus($sformatf("hold_b%0d", k), 1'b0, 1'b1, 8'h41, 1'b1);
    end
    applyStimulus("hold_c0", 1'b0, 1'b0, 8'h00, 1'b1);
    applyStimulus("hold_c1", 1'b0, 1'b0, 8'h00, 1'b1);
    checkVal("hold_hs_count", hs.size(), 4);
    checkVal("hold_hs0", (hs.size() > 0) ? hs[0] : -1, 1);
    checkVal("hold_hs1", (hs.size() > 1) ? hs[1] : -1, 2);
    checkVal("hold_hs2", (hs.size() > 2) ? hs[2] : -1, 0);
    checkVal("hold_hs3", (hs.size() > 3) ? hs[3] : -1, 6);

    // Random traffic against the model
    for (int c = 0; c < 400; c++) begin
      sel = $urandom_range(0, 9);
      if (sel == 0)      v = 8'h00;
      else if (sel == 1) v = 8'hFF;
      else               v = 8'($urandom);
      r = ($urandom_range(0, 39) == 0);
      applyStimulus($sformatf("rnd%0d", c), r, 1'($urandom), v, 1'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
